// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-side bus of the ALU op sequencer.
// Combinational bundle only; no latency of its own.
// Backpressure via cmd_valid/cmd_ready and rsp_valid/rsp_ready.
`timescale 1ns/1ps
interface alu_op_sequencer_if #(
  parameter int DATA_W = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_W-1:0]     cmd_a;
  logic [DATA_W-1:0]     cmd_b;
  logic [2:0]            cmd_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*DATA_W-1:0]   rsp_result;
  logic [2:0]            rsp_op;
  logic                  rsp_timeout;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [2:0]            alu_op;
  logic                  alu_start;
  logic                  alu_reset_n;
  logic                  alu_done;
  logic [2*DATA_W-1:0]   alu_result;
  logic                  busy;

  // sequencer side
  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
    output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_timeout,
           alu_a, alu_b, alu_op, alu_start, alu_reset_n, busy
  );

  // producer / consumer / ALU side
  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
    input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_timeout,
           alu_a, alu_b, alu_op, alu_start, alu_reset_n, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands and runs them one at a time over the start/done handshake.
// Latency: pop to rsp_valid is 3 cycles for an op whose done follows start by 1 cycle.
// Backpressure: cmd_ready drops when the FIFO is full; a stalled response holds the FSM.
// Optional ALU_SEQ_STATS_EN adds saturating stat_ops / stat_timeouts counters.
`timescale 1ns/1ps
module alu_op_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_op_sequencer_if.master  bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_timeouts
`endif
);
  localparam int RES_W = 2 * DATA_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_NOP, S_RST, S_RESP} state_t;

  cmd_t              r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic              w_full, w_empty, w_push, w_pop;
  cmd_t              w_head, w_cmd_in;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_alu_a, w_alu_a_nxt, r_alu_b, w_alu_b_nxt;
  logic [2:0]        r_alu_op, w_alu_op_nxt;
  logic              r_alu_start, w_alu_start_nxt;
  logic              r_alu_reset_n, w_alu_reset_n_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [RES_W-1:0]  r_rsp_result, w_rsp_result_nxt;
  logic [2:0]        r_rsp_op, w_rsp_op_nxt;
  logic              r_rsp_timeout, w_rsp_timeout_nxt;

  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_push   = bus.cmd_valid && !w_full;
  assign w_pop    = (r_state == S_IDLE) && !w_empty;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_cmd_in = '{op: bus.cmd_op, b: bus.cmd_b, a: bus.cmd_a};

  // command storage; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_cmd_in;
  end

  // FIFO pointers with a wrap bit to tell full from empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // next-state and next registered outputs of the sequencing FSM
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_alu_a_nxt       = r_alu_a;
    w_alu_b_nxt       = r_alu_b;
    w_alu_op_nxt      = r_alu_op;
    w_alu_start_nxt   = r_alu_start;
    w_alu_reset_n_nxt = 1'b1;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_result_nxt  = r_rsp_result;
    w_rsp_op_nxt      = r_rsp_op;
    w_rsp_timeout_nxt = r_rsp_timeout;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_alu_a_nxt  = w_head.a;
          w_alu_b_nxt  = w_head.b;
          w_alu_op_nxt = w_head.op;
          w_cnt_nxt    = CW'(1);
          case (w_head.op)
            3'b001, 3'b010, 3'b011, 3'b100: begin
              w_state_nxt     = S_EXEC;
              w_alu_start_nxt = 1'b1;
            end
            3'b111: begin
              w_state_nxt       = S_RST;
              w_alu_reset_n_nxt = 1'b0;
            end
            default: begin
              // 000 and the unused codes all behave as no_op
              w_state_nxt     = S_NOP;
              w_alu_start_nxt = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        if (bus.alu_done) begin
          w_state_nxt       = S_RESP;
          w_alu_start_nxt   = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_result_nxt  = bus.alu_result;
          w_rsp_op_nxt      = r_alu_op;
          w_rsp_timeout_nxt = 1'b0;
        end else if (r_cnt == CW'(TIMEOUT)) begin
          w_state_nxt       = S_RESP;
          w_alu_start_nxt   = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_result_nxt  = '0;
          w_rsp_op_nxt      = r_alu_op;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_NOP: begin
        w_state_nxt       = S_RESP;
        w_alu_start_nxt   = 1'b0;
        w_rsp_valid_nxt   = 1'b1;
        w_rsp_result_nxt  = '0;
        w_rsp_op_nxt      = r_alu_op;
        w_rsp_timeout_nxt = 1'b0;
      end
      S_RST: begin
        // alu_reset_n was dropped on entry; hold it for a second cycle
        if (r_cnt == CW'(2)) begin
          w_state_nxt       = S_RESP;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_result_nxt  = '0;
          w_rsp_op_nxt      = r_alu_op;
          w_rsp_timeout_nxt = 1'b0;
        end else begin
          w_alu_reset_n_nxt = 1'b0;
          w_cnt_nxt         = r_cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state and all ALU/response outputs are registered here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_alu_start   <= 1'b0;
      r_alu_reset_n <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_op      <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_alu_a       <= w_alu_a_nxt;
      r_alu_b       <= w_alu_b_nxt;
      r_alu_op      <= w_alu_op_nxt;
      r_alu_start   <= w_alu_start_nxt;
      r_alu_reset_n <= w_alu_reset_n_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_result  <= w_rsp_result_nxt;
      r_rsp_op      <= w_rsp_op_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign bus.cmd_ready   = !w_full;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_op      = r_rsp_op;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_start   = r_alu_start;
  assign bus.alu_reset_n = r_alu_reset_n;
  assign bus.busy        = (r_state != S_IDLE);

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] r_stat_ops, r_stat_timeouts;

  // saturating counts of handshaked responses and of timed-out ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_ops      <= '0;
      r_stat_timeouts <= '0;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      if (r_stat_ops != 16'hFFFF) r_stat_ops <= r_stat_ops + 16'd1;
      if (r_rsp_timeout && (r_stat_timeouts != 16'hFFFF)) r_stat_timeouts <= r_stat_timeouts + 16'd1;
    end
  end

  assign stat_ops      = r_stat_ops;
  assign stat_timeouts = r_stat_timeouts;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised scoreboard bench for alu_op_sequencer with a behavioural ALU responder.
// Expected responses are queued on command acceptance and popped on the response handshake.
// Response backpressure is forced, released or randomised per phase.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  alu_op_sequencer_if #(.DATA_W(DATA_W)) bus();

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_timeouts;
`endif

  alu_op_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops(stat_ops),
    .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] result;
    logic        timeout;
    int          start_cyc;
    int          rstlow_cyc;
  } exp_t;

  exp_t sb[$];
  int   delay_q[$];
  int   n_cmp = 0, n_err = 0;
  int   n_acc = 0, n_resp = 0, n_to = 0;
  int   rdy_mode = 1;        // 0: hold rsp_ready low, 1: high, 2: random
  int   start_tot = 0, rstlow_tot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_exec(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
  endfunction

  // arithmetic meaning of each opcode, used both by the ALU stand-in and the reference
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd1:    return 16'(ia + ib);
      3'd2:    return 16'(ia & ib);
      3'd3:    return 16'(ia ^ ib);
      3'd4:    return 16'(ia * ib);
      default: return 16'h0;
    endcase
  endfunction

  // reference outcome of one command; d = done delay after start, 0 = never
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int d);
    exp_t e;
    e.op = op; e.result = 16'h0; e.timeout = 1'b0; e.start_cyc = 0; e.rstlow_cyc = 0;
    if (is_exec(op)) begin
      if (d == 0) begin
        e.timeout = 1'b1;
        e.start_cyc = TIMEOUT;
      end else begin
        e.result = alu_fn(op, a, b);
        e.start_cyc = d + 1;
      end
    end else if (op == 3'd7) begin
      e.rstlow_cyc = 2;
    end else begin
      e.start_cyc = 1;
    end
    return e;
  endfunction

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int d, input int max_wait, output bit acc);
    acc = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    for (int g = 0; g < max_wait; g++) begin
      if (bus.cmd_ready) begin
        sb.push_back(model(op, a, b, d));
        if (is_exec(op)) delay_q.push_back(d);
        n_acc++;
        acc = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int d);
    bit acc;
    send(op, a, b, d, 3000, acc);
    check("cmd_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain();
    for (int g = 0; g < 3000 && n_resp < n_acc; g++) @(negedge clk);
    check("drain_all", n_resp, n_acc);
    repeat (2) @(negedge clk);
  endtask

  // ALU stand-in: answers exec ops after the queued delay, injects stray done pulses
  initial begin
    int cnt;
    bit prev;
    cnt = -1;
    prev = 1'b0;
    bus.alu_done = 1'b0;
    bus.alu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.alu_done = 1'b0;
      bus.alu_result = 16'($urandom);
      if (!reset_n) begin
        cnt = -1;
        prev = 1'b0;
      end else begin
        if (bus.alu_start) start_tot++;
        if (!bus.alu_reset_n) rstlow_tot++;
        if (bus.alu_start && !prev && is_exec(bus.alu_op)) begin
          if (delay_q.size() == 0) begin
            n_err++;
            $display("FAIL alu_start_unexpected: got start for op %0d expected none", bus.alu_op);
            cnt = -1;
          end else begin
            int d;
            d = delay_q.pop_front();
            cnt = (d == 0) ? -1 : d;
          end
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.alu_done = 1'b1;
            bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
            cnt = -1;
          end
        end else if (!bus.alu_start && $urandom_range(0, 3) == 0) begin
          bus.alu_done = 1'b1;
        end
        prev = bus.alu_start;
      end
    end
  end

  // response consumer
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // scoreboard monitor
  initial begin
    int snap_s, snap_r;
    bit idle_chk;
    exp_t e;
    snap_s = 0; snap_r = 0; idle_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        snap_s = start_tot;
        snap_r = rstlow_tot;
        idle_chk = 1'b0;
      end else begin
        if (idle_chk) begin
          check("busy_after_hs", 32'(bus.busy), 32'd0);
          idle_chk = 1'b0;
        end
        if (bus.rsp_valid) begin
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_rsp: got op %0d result %0h expected no response", bus.rsp_op, bus.rsp_result);
          end else begin
            e = sb[0];
            if (!bus.rsp_ready) begin
              check("rsp_hold", {12'h0, bus.rsp_op, bus.rsp_timeout, bus.rsp_result},
                    {12'h0, e.op, e.timeout, e.result});
            end else begin
              check("rsp_result", 32'(bus.rsp_result), 32'(e.result));
              check("rsp_op", 32'(bus.rsp_op), 32'(e.op));
              check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
              check("busy_in_resp", 32'(bus.busy), 32'd1);
              check("start_cycles", start_tot - snap_s, e.start_cyc);
              check("alu_rst_cycles", rstlow_tot - snap_r, e.rstlow_cyc);
              snap_s = start_tot;
              snap_r = rstlow_tot;
              if (e.timeout) n_to++;
              void'(sb.pop_front());
              n_resp++;
              idle_chk = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    int n_bp, r0, g;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    reset_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_alu_start", 32'(bus.alu_start), 32'd0);
    check("rst_alu_reset_n", 32'(bus.alu_reset_n), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_alu_ab", {16'h0, bus.alu_a, bus.alu_b}, 32'd0);

    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1 check("alu_reset_n_release", 32'(bus.alu_reset_n), 32'd1);

    rdy_mode = 1;
    send_cmd(3'd1, 8'hFF, 8'h01, 1);
    wait_drain();
    send_cmd(3'd4, 8'hFF, 8'hFF, 3);
    send_cmd(3'd3, 8'hA5, 8'h0F, 2);
    wait_drain();
    send_cmd(3'd2, 8'h3C, 8'hF0, 0);
    wait_drain();
    send_cmd(3'd7, 8'h12, 8'h34, 1);
    send_cmd(3'd0, 8'h55, 8'h66, 1);
    send_cmd(3'd5, 8'h77, 8'h88, 1);
    wait_drain();

    // six offers against a stalled response path
    rdy_mode = 0;
    n_bp = 0;
    for (int i = 0; i < 6; i++) begin
      send(3'(i % 5), 8'(i * 17 + 3), 8'(i * 29 + 1), 1 + (i % 3), 1, acc);
      if (acc) n_bp++;
    end
    check("bp_accepted", n_bp, 5);
    check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    rdy_mode = 1;
    wait_drain();

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      int d;
      op = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      send_cmd(op, 8'($urandom), 8'($urandom), d);
    end
    wait_drain();
    rdy_mode = 1;

`ifdef ALU_SEQ_STATS_EN
    check("stat_ops", 32'(stat_ops), n_resp);
    check("stat_timeouts", 32'(stat_timeouts), n_to);
`endif

    // reset while an op is executing, with more commands queued behind it
    send_cmd(3'd1, 8'h01, 8'h02, 0);
    send_cmd(3'd3, 8'h0F, 8'hF0, 1);
    send_cmd(3'd4, 8'h10, 8'h10, 2);
    g = 0;
    while (!bus.alu_start && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("exec_reached", 32'(bus.alu_start), 32'd1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("abort_alu_start", 32'(bus.alu_start), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_alu_reset_n", 32'(bus.alu_reset_n), 32'd0);
    sb.delete();
    delay_q.delete();
    n_acc = n_resp;
`ifdef ALU_SEQ_STATS_EN
    check("stat_ops_cleared", 32'(stat_ops), 32'd0);
`endif
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    r0 = n_resp;
    repeat (40) @(negedge clk);
    check("no_rsp_after_abort", n_resp, r0);
    check("idle_after_abort", 32'(bus.busy), 32'd0);

    send_cmd(3'd1, 8'h80, 8'h80, 2);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #800000;
    $display("FAIL watchdog: got no completion expected finish before 800000");
    $fatal(1);
  end
endmodule
